conv_window_ctrl: RTL and testbench

//   Sequences the 3x3 convolution unit over a stored IMG_W x IMG_H image for valid (no-pad) windows.

---
 rtl/conv_window_ctrl.sv | 172 +++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Window sequencer for a 3x3 convolution unit over a stored image.
// Fetches each valid window from pixel RAM and streams the unit's sums out.
module conv_window_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 6,
  parameter int SUM_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ker_we,
  input  logic [3:0]         ker_idx,
  input  logic [PIX_W-1:0]   ker_data,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic [9*PIX_W-1:0] win_pix,
  output logic [9*PIX_W-1:0] win_ker,
  input  logic [SUM_W-1:0]   conv_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_THREE = ADDR_W'(3);

  logic [2:0]              r_state;
  logic [3:0]              r_k;
  logic [1:0]              r_kc;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic [ADDR_W-1:0]       r_base;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_rd_en;
  logic [8:0][PIX_W-1:0]   r_pix;
  logic [8:0][PIX_W-1:0]   r_ker;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_eol;
  logic                    w_last;
  logic [ADDR_W-1:0]       w_next_base;

  assign w_eol  = (r_col == LAST_COL);
  assign w_last = w_eol && (r_row == LAST_ROW);
  // Origin of the next raster window: +1 along a row, +3 wraps to next row.
  assign w_next_base = w_eol ? r_base + A_THREE : r_base + A_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_kc        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_rd_en     <= 1'b0;
      r_pix       <= '0;
      r_ker       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ker_we && (ker_idx < 4'd9))
            r_ker[ker_idx] <= ker_data;
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_k     <= '0;
            r_kc    <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data trails the address by one cycle.
          if (r_k != 4'd0)
            r_pix[r_k - 4'd1] <= mem_rdata;
          if (r_k == 4'd9) begin
            r_k     <= '0;
            r_state <= S_CONV;
          end else begin
            r_k <= r_k + 4'd1;
            if (r_k == 4'd8) begin
              r_rd_en <= 1'b0;
            end else if (r_kc == 2'd2) begin
              r_kc   <= '0;
              r_addr <= r_addr + ROW_STEP;
            end else begin
              r_kc   <= r_kc + 2'd1;
              r_addr <= r_addr + A_ONE;
            end
          end
        end
        S_CONV: begin
          r_out_valid <= 1'b1;
          r_out_last  <= w_last;
          r_state     <= S_RESULT;
        end
        S_RESULT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              if (w_eol) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
              r_base  <= w_next_base;
              r_addr  <= w_next_base;
              r_kc    <= '0;
              r_rd_en <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign win_pix   = r_pix;
  assign win_ker   = r_ker;
  assign out_valid = r_out_valid;
  // The unit's sum is registered and held while the window is stable.
  assign out_data  = r_out_valid ? conv_sum : '0;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: 8x8 and 3x3 instances with RAM and unit models.
// Results and read addresses are checked against a window-arithmetic model.
module tb_conv_window_ctrl;

  localparam int PW = 4;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  logic           a_start = 0, a_kwe = 0;
  logic [3:0]     a_kidx = 0;
  logic [PW-1:0]  a_kdat = 0;
  logic           a_rd;
  logic [5:0]     a_addr;
  logic [PW-1:0]  a_rdata = 0;
  logic [9*PW-1:0] a_wp, a_wk;
  logic [SW-1:0]  a_sum = 0, a_od;
  logic           a_ov, a_ordy = 0, a_ol, a_busy, a_done;

  logic           b_start = 0, b_kwe = 0;
  logic [3:0]     b_kidx = 0;
  logic [PW-1:0]  b_kdat = 0;
  logic           b_rd;
  logic [3:0]     b_addr;
  logic [PW-1:0]  b_rdata = 0;
  logic [9*PW-1:0] b_wp, b_wk;
  logic [SW-1:0]  b_sum = 0, b_od;
  logic           b_ov, b_ordy = 0, b_ol, b_busy, b_done;

  conv_window_ctrl #(
    .IMG_W(8), .IMG_H(8), .PIX_W(PW), .ADDR_W(6), .SUM_W(SW)
  ) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .ker_we(a_kwe), .ker_idx(a_kidx), .ker_data(a_kdat),
    .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .win_pix(a_wp), .win_ker(a_wk), .conv_sum(a_sum),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
    .out_last(a_ol), .busy(a_busy), .done(a_done)
  );

  conv_window_ctrl #(
    .IMG_W(3), .IMG_H(3), .PIX_W(PW), .ADDR_W(4), .SUM_W(SW)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .ker_we(b_kwe), .ker_idx(b_kidx), .ker_data(b_kdat),
    .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .win_pix(b_wp), .win_ker(b_wk), .conv_sum(b_sum),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
    .out_last(b_ol), .busy(b_busy), .done(b_done)
  );

  int img_a[64];
  int img_b[16];
  int ker_a[9];
  int rdq_a[$];

  function automatic logic [SW-1:0] dot(
    input logic [9*PW-1:0] p, input logic [9*PW-1:0] k);
    int s = 0;
    for (int i = 0; i < 9; i++)
      s += int'(p[i*PW +: PW]) * int'(k[i*PW +: PW]);
    return SW'(s);
  endfunction

  always @(posedge clk) begin
    if (a_rd) begin
      a_rdata <= PW'(img_a[a_addr]);
      rdq_a.push_back(int'(a_addr));
    end
    if (b_rd) b_rdata <= PW'(img_b[b_addr]);
    a_sum <= dot(a_wp, a_wk);
    b_sum <= dot(b_wp, b_wk);
  end

  function automatic int addr_a(input int w, input int k);
    return (w / 6 + k / 3) * 8 + (w % 6) + (k % 3);
  endfunction

  function automatic int exp_a(input int w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += ker_a[k] * img_a[addr_a(w, k)];
    return s;
  endfunction

  function automatic logic [9*PW-1:0] pack_ker();
    logic [9*PW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*PW +: PW] = PW'(ker_a[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ker_a();
    for (int i = 0; i < 9; i++) begin
      a_kwe = 1; a_kidx = 4'(i); a_kdat = PW'(ker_a[i]);
      @(negedge clk);
    end
    a_kwe = 0;
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_ov) begin ok = 1; return; end
      @(negedge clk);
    end
  endtask

  task automatic run_a(input bit bp, input bit poke);
    int c0, prev, nrd, bad;
    bit ok, stable;
    logic [SW-1:0] d;
    int w1[9] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};
    rdq_a.delete();
    a_ordy = !bp;
    a_start = 1; c0 = cyc;
    @(negedge clk);
    a_start = 0;
    if (poke) begin
      a_start = 1; a_kwe = 1; a_kidx = 0; a_kdat = 4'd15;
      @(negedge clk);
      a_start = 0; a_kwe = 0;
    end
    prev = 0;
    for (int w = 0; w < 36; w++) begin
      wait_valid_a(ok);
      chk("valid_timeout", ok, 1);
      if (!ok) break;
      if (w == 0) begin
        chk("latency", cyc - c0, 12);
        chk("busy", a_busy, 1);
      end else if (!bp) begin
        chk("period", cyc - prev, 12);
      end
      prev = cyc;
      chk("data", a_od, exp_a(w));
      chk("last", a_ol, w == 35);
      if (bp) begin
        d = a_od; nrd = rdq_a.size(); stable = 1;
        repeat (5) begin
          @(negedge clk);
          stable &= (a_ov === 1'b1) && (a_od === d);
        end
        chk("bp_stable", stable, 1);
        chk("bp_noread", rdq_a.size(), nrd);
        a_ordy = 1;
        @(negedge clk);
        a_ordy = 0;
        chk("bp_accept", a_ov, 0);
      end else begin
        @(negedge clk);
      end
    end
    chk("done", a_done, 1);
    @(negedge clk);
    chk("done_pulse", a_done, 0);
    chk("idle", a_busy, 0);
    chk("rd_count", rdq_a.size(), 324);
    if (rdq_a.size() == 324) begin
      bad = 0;
      for (int w = 0; w < 36; w++)
        for (int k = 0; k < 9; k++)
          if (rdq_a[w*9+k] != addr_a(w, k)) bad++;
      chk("addr_all", bad, 0);
      for (int k = 0; k < 9; k++) chk("win1_addr", rdq_a[9+k], w1[k]);
      chk("row1_addr", rdq_a[54], 8);
    end
    chk("win_ker", a_wk, pack_ker());
  endtask

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_ov, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_pix", a_wp, 0);
    chk("rst_ker", a_wk, 0);
    chk("rst_data", a_od, 0);
    chk("rst_done", a_done, 0);
    rst = 0;
    @(negedge clk);

    // Single 3x3 window
    for (int i = 0; i < 16; i++) img_b[i] = (i < 9) ? i + 1 : 0;
    for (int i = 0; i < 9; i++) begin
      b_kwe = 1; b_kidx = 4'(i); b_kdat = 4'd1;
      @(negedge clk);
    end
    b_kwe = 0; b_ordy = 1;
    b_start = 1; c0 = cyc;
    @(negedge clk);
    b_start = 0;
    for (int i = 0; i < 40 && !b_ov; i++) @(negedge clk);
    chk("b_valid", b_ov, 1);
    chk("b_latency", cyc - c0, 12);
    chk("b_data", b_od, 45);
    chk("b_last", b_ol, 1);
    @(negedge clk);
    chk("b_done", b_done, 1);
    chk("b_valid_drop", b_ov, 0);
    @(negedge clk);
    chk("b_done_pulse", b_done, 0);
    chk("b_idle", b_busy, 0);

    // Random image and kernel, ready tied high
    for (int i = 0; i < 64; i++) img_a[i] = int'($urandom_range(0, 15));
    for (int i = 0; i < 9; i++) ker_a[i] = int'($urandom_range(0, 15));
    ker_a[0] = int'($urandom_range(0, 14));
    load_ker_a();
    run_a(0, 0);

    // Backpressure plus start/ker_we pokes while busy
    for (int i = 0; i < 64; i++) img_a[i] = int'($urandom_range(0, 15));
    run_a(1, 1);

    // Out-of-range kernel index in IDLE
    a_kwe = 1; a_kidx = 4'd12; a_kdat = 4'd7;
    @(negedge clk);
    a_kwe = 0;
    @(negedge clk);
    chk("ker_idx12", a_wk, pack_ker());

    // All-max operands
    for (int i = 0; i < 64; i++) img_a[i] = 15;
    for (int i = 0; i < 9; i++) ker_a[i] = 15;
    load_ker_a();
    run_a(0, 0);

    // Reset mid-FETCH
    a_ordy = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_rd", a_rd, 1);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("t1_busy", a_busy, 0);
    chk("t1_valid", a_ov, 0);
    chk("t1_rd", a_rd, 0);
    chk("t1_pix", a_wp, 0);
    chk("t1_ker", a_wk, 0);
    chk("t1_done", a_done, 0);
    @(negedge clk);
    chk("t1_no_done", a_done, 0);

    // Kernel cleared by reset: every result is zero
    for (int i = 0; i < 64; i++) img_a[i] = int'($urandom_range(0, 15));
    for (int i = 0; i < 9; i++) ker_a[i] = 0;
    run_a(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
